// File: rtl/ghost_maze_sensor.sv
// ghost_maze_sensor
// -----------------------------------------------------------------------------
// Purpose: answers "which of my four neighbouring tiles are open?" for a ghost.
// A start pulse while idle latches the ghost tile (posX, posY). The block then
// reads the maze wall map for the up, right, down and left neighbours, one read
// per cycle. All four canMove flags are published together with a one-cycle done
// pulse five edges after the start edge.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start, posX, posY   query request and ghost tile, sampled while idle
//   mapRd               map read strobe (decoded from state, not registered)
//   mapAddrX, mapAddrY  map read address (decoded from state and latched tile)
//   mapWall             wall bit, valid the cycle after mapRd
//   canMoveU/R/D/L      registered open flags, held between queries
//   busy                registered, high while a query is in progress
//   done                registered one-cycle pulse when the flags update
// -----------------------------------------------------------------------------
module ghost_maze_sensor #(
  parameter int POS_W = 5,
  parameter int MAP_W = 28,
  parameter int MAP_H = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [POS_W-1:0] posX,
  input  logic [POS_W-1:0] posY,
  output logic             mapRd,
  output logic [POS_W-1:0] mapAddrX,
  output logic [POS_W-1:0] mapAddrY,
  input  logic             mapWall,
  output logic             canMoveU,
  output logic             canMoveR,
  output logic             canMoveD,
  output logic             canMoveL,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_U   = 3'd1,
    S_RD_R   = 3'd2,
    S_RD_D   = 3'd3,
    S_RD_L   = 3'd4,
    S_WAIT_L = 3'd5
  } state_t;

  localparam logic [POS_W-1:0] LP_ONE   = POS_W'(1);
  localparam logic [POS_W-1:0] LP_X_MAX = POS_W'(MAP_W - 1);
  localparam logic [POS_W-1:0] LP_Y_MAX = POS_W'(MAP_H - 1);

  state_t           r_state;
  state_t           w_next;
  logic [POS_W-1:0] r_x;
  logic [POS_W-1:0] r_y;
  logic             r_rd_d;      // a real read was issued in the previous cycle
  logic             r_wall_u;
  logic             r_wall_r;
  logic             r_wall_d;
  logic [3:0]       r_flags;     // {U, R, D, L}
  logic             r_busy;
  logic             r_done;

  logic             w_oor;
  logic             w_top;
  logic             w_bot;
  logic [POS_W-1:0] w_x_right;
  logic [POS_W-1:0] w_x_left;
  logic [POS_W-1:0] w_y_up;
  logic [POS_W-1:0] w_y_down;
  logic             w_rd;
  logic [POS_W-1:0] w_ax;
  logic [POS_W-1:0] w_ay;
  logic             w_wall;

  // A latched tile outside the maze suppresses every read.
  assign w_oor = (r_x > LP_X_MAX) | (r_y > LP_Y_MAX);
  assign w_top = (r_y == '0);
  assign w_bot = (r_y == LP_Y_MAX);

  // Horizontal tunnel wrap is explicit so it does not depend on POS_W overflow.
  assign w_x_right = (r_x == LP_X_MAX) ? '0 : (r_x + LP_ONE);
  assign w_x_left  = (r_x == '0) ? LP_X_MAX : (r_x - LP_ONE);
  assign w_y_up    = r_y - LP_ONE;
  assign w_y_down  = r_y + LP_ONE;

  // A slot that issued no read (vertical edge or out of range) is treated as a wall.
  assign w_wall = r_rd_d ? mapWall : 1'b1;

  // Next-state sequencing and read-port decode from the current state.
  always_comb begin
    w_next = r_state;
    w_rd   = 1'b0;
    w_ax   = '0;
    w_ay   = '0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_RD_U;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_RD_U: begin
        w_next = S_RD_R;
        w_rd   = ~w_oor & ~w_top;
        w_ax   = r_x;
        w_ay   = w_y_up;
      end
      S_RD_R: begin
        w_next = S_RD_D;
        w_rd   = ~w_oor;
        w_ax   = w_x_right;
        w_ay   = r_y;
      end
      S_RD_D: begin
        w_next = S_RD_L;
        w_rd   = ~w_oor & ~w_bot;
        w_ax   = r_x;
        w_ay   = w_y_down;
      end
      S_RD_L: begin
        w_next = S_WAIT_L;
        w_rd   = ~w_oor;
        w_ax   = w_x_left;
        w_ay   = r_y;
      end
      S_WAIT_L: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign mapRd    = w_rd;
  assign mapAddrX = w_ax;
  assign mapAddrY = w_ay;

  // State register, tile latch and read-issued tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_rd_d  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rd_d  <= w_rd;
      r_busy  <= (w_next != S_IDLE);
      if ((r_state == S_IDLE) && start) begin
        r_x <= posX;
        r_y <= posY;
      end
    end
  end

  // Wall capture one state after each read, and atomic flag publish at the end.
  // The left wall is consumed directly from w_wall at the publishing edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wall_u <= 1'b1;
      r_wall_r <= 1'b1;
      r_wall_d <= 1'b1;
      r_flags  <= 4'b0000;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RD_R:   r_wall_u <= w_wall;
        S_RD_D:   r_wall_r <= w_wall;
        S_RD_L:   r_wall_d <= w_wall;
        S_WAIT_L: begin
          r_flags <= ~{r_wall_u, r_wall_r, r_wall_d, w_wall};
          r_done  <= 1'b1;
        end
        default: begin
          r_flags <= r_flags;
        end
      endcase
    end
  end

  assign canMoveU = r_flags[3];
  assign canMoveR = r_flags[2];
  assign canMoveD = r_flags[1];
  assign canMoveL = r_flags[0];
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/ghost_maze_sensor.md
Name: ghost_maze_sensor

Overview:
- Produces the four wall-clearance flags (canMoveU, canMoveR, canMoveD, canMoveL) that the ghost direction-selection logic consumes.
- On a start pulse it latches a ghost tile position and queries the shared maze wall map for the four neighbouring tiles, one read per cycle.
- It publishes all four flags atomically, with a done pulse, once the last read returns.
- It sits between the ghost position registers and the maze map ROM read port.

Parameters:
- POS_W, 5, width of tile coordinates.
- MAP_W, 28, maze width in tiles; columns 0..MAP_W-1.
- MAP_H, 31, maze height in tiles; rows 0..MAP_H-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a neighbour query; sampled on rising edge while idle.
- posX  input  POS_W  ghost tile column; latched with start.
- posY  input  POS_W  ghost tile row; latched with start.
- mapRd  output  1  map read strobe.
- mapAddrX  output  POS_W  map read column.
- mapAddrY  output  POS_W  map read row.
- mapWall  input  1  wall bit (1 = wall); valid the cycle after mapRd.
- canMoveU  output  1  up neighbour is open.
- canMoveR  output  1  right neighbour is open.
- canMoveD  output  1  down neighbour is open.
- canMoveL  output  1  left neighbour is open.
- busy  output  1  query in progress.
- done  output  1  one-cycle pulse when the flags update.

Behaviour:
- Reset (asynchronous, any state): state IDLE; canMove* = 0, done = 0, busy = 0, mapRd = 0, mapAddrX/Y = 0, latched position = 0.
- States: IDLE, RD_U, RD_R, RD_D, RD_L, WAIT_L.
- IDLE: start=1 at edge E0 latches posX/posY and moves to RD_U. Otherwise stays in IDLE.
- Sequence: RD_U -> RD_R -> RD_D -> RD_L -> WAIT_L -> IDLE, advancing one state per edge E1..E5.
- busy = 1 in every state except IDLE.
- Read slots: RD_U=(x, y-1), RD_R=(x+1, y), RD_D=(x, y+1), RD_L=(x-1, y).
  - mapRd is combinational from state; addresses are driven from the latched position.
- Capture: mapWall for slot k is sampled at the edge that leaves the state following slot k.
  - U is captured at E2, R at E3, D at E4, L at E5, into shadow bits.
- Update: at E5, canMove* <= ~wall for all four directions simultaneously, and done <= 1.
  - done deasserts at the next edge.
  - canMove* hold their value until the next completed query.
- Horizontal wrap (tunnel):
  - x = 0: left read address is MAP_W-1.
  - x = MAP_W-1: right read address is 0.
  - Compute wrap explicitly; do not rely on POS_W overflow.
- Vertical edges:
  - y = 0: RD_U slot keeps mapRd = 0 and forces wall = 1.
  - y = MAP_H-1: RD_D slot does the same.
  - Timing is unchanged in both cases: always 5 cycles from E0 to update.
- Out-of-range latch (x >= MAP_W or y >= MAP_H): no reads are issued (mapRd = 0 in all slots), the sequence still runs, and all four flags result 0.
- start while busy (including during WAIT_L) is ignored. The next start is accepted at the first edge in IDLE, i.e. E6 at the earliest.
- Reset mid-query aborts the query: no done, flags forced 0.
- All outputs are registered except mapRd and mapAddrX/Y, which decode from state and the latched position only, never from inputs.

Test Plan:
1. Reset: assert reset mid-run at an arbitrary phase -> all outputs 0 immediately (asynchronous), state IDLE, no done afterwards.
2. Interior cell: start with pos=(5,5), map walls at (5,4) only -> reads (5,4),(6,5),(5,6),(4,5) on E1..E4 cycles; at E5 U=0, R=1, D=1, L=1; done high exactly one cycle; busy high E0..E5.
3. Tunnel: pos=(0,14), all open -> RD_R addr (1,14), RD_L addr (27,14); all flags 1. Then pos=(27,14) -> RD_R addr (0,14).
4. Vertical edges: pos=(3,0) -> mapRd=0 during RD_U, canMoveU=0, others follow map. Then pos=(3,30) -> mapRd=0 during RD_D, canMoveD=0.
5. Start while busy: pulse start at E2 with pos=(9,9) -> ignored; result reflects the first position. Start at E6 with pos=(9,9) -> new query, done at E11.
6. Out-of-range: pos=(28,5) -> no mapRd asserted throughout; at E5 all flags 0 and done pulses.
